// File: rtl/reg_file_mp_sb.sv
// Multi-port register file with per-register busy scoreboard and optional writeback bypass.
// Reads are combinational; writes, reservations and releases take effect at the edge; no backpressure.
module reg_file_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 4,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rready,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    iaddr,
    input  logic [NWR-1:0]       ien,
    input  logic                 flush,
    output logic [NREG-1:0]      busy
);

    localparam int unsigned NREG_U = NREG;

    // Addresses past NREG (non power-of-two depths) and r0 when hardwired are never stored.
    function automatic logic legal(input logic [AW-1:0] a);
        return (32'(a) < NREG_U) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [NWR-1:0]  wlegal;
    logic [NWR-1:0]  ilegal;

    logic [NREG-1:0] wr_hit;
    logic [XLEN-1:0] wr_dat [NREG];
    logic [NREG-1:0] set_v;
    logic [NREG-1:0] clr_v;

    always_comb begin
        wlegal = '0;
        ilegal = '0;
        for (int j = 0; j < NWR; j++) begin
            wlegal[j] = wen[j] && legal(waddr[j*AW +: AW]);
            ilegal[j] = ien[j] && legal(iaddr[j*AW +: AW]);
        end
    end

    // Ascending port scan: the highest-numbered matching write port overrides earlier ones.
    always_comb begin
        wr_hit = '0;
        set_v  = '0;
        clr_v  = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_dat[i] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wlegal[j] && (waddr[j*AW +: AW] == AW'(i))) begin
                    wr_hit[i] = 1'b1;
                    clr_v[i]  = 1'b1;
                    wr_dat[i] = wdata[j*XLEN +: XLEN];
                end
                if (ilegal[j] && (iaddr[j*AW +: AW] == AW'(i))) begin
                    set_v[i] = 1'b1;
                end
            end
        end
    end

    // A reservation always wins, so re-issuing a destination during its own writeback stays pending.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (set_v[i]) begin
                busy_d[i] = 1'b1;
            end else if (flush || clr_v[i]) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_hit[i]) begin
                    mem[i] <= wr_dat[i];
                end
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic            byp_hit;
        logic [XLEN-1:0] byp_dat;
        rdata   = '0;
        rready  = '1;
        ra      = '0;
        byp_hit = 1'b0;
        byp_dat = '0;
        for (int k = 0; k < NRD; k++) begin
            ra      = raddr[k*AW +: AW];
            byp_hit = 1'b0;
            byp_dat = '0;
            if (legal(ra)) begin
                for (int j = 0; j < NWR; j++) begin
                    if ((BYPASS != 0) && wlegal[j] && (waddr[j*AW +: AW] == ra)) begin
                        byp_hit = 1'b1;
                        byp_dat = wdata[j*XLEN +: XLEN];
                    end
                end
                if (byp_hit) begin
                    rdata[k*XLEN +: XLEN] = byp_dat;
                    rready[k]             = 1'b1;
                end else begin
                    rdata[k*XLEN +: XLEN] = mem[ra];
                    rready[k]             = !busy_q[ra];
                end
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Directed table plus model-checked random traffic for three parameterisations of reg_file_mp_sb.
module tb_reg_file_mp_sb;

    logic clk;
    logic rst_n;

    // A: defaults (32 regs, 4R/2W, bypass, hardwired r0)
    logic [19:0]  a_raddr;
    logic [127:0] a_rdata;
    logic [3:0]   a_rready;
    logic [9:0]   a_waddr;
    logic [63:0]  a_wdata;
    logic [1:0]   a_wen;
    logic [9:0]   a_iaddr;
    logic [1:0]   a_ien;
    logic         a_flush;
    logic [31:0]  a_busy;

    // B: 24 regs, 2R/2W, bypass, r0 is an ordinary register
    logic [9:0]   b_raddr;
    logic [63:0]  b_rdata;
    logic [1:0]   b_rready;
    logic [9:0]   b_waddr;
    logic [63:0]  b_wdata;
    logic [1:0]   b_wen;
    logic [9:0]   b_iaddr;
    logic [1:0]   b_ien;
    logic         b_flush;
    logic [23:0]  b_busy;

    // C: 16 regs, 6R/3W, no bypass, hardwired r0
    logic [23:0]  c_raddr;
    logic [191:0] c_rdata;
    logic [5:0]   c_rready;
    logic [11:0]  c_waddr;
    logic [95:0]  c_wdata;
    logic [2:0]   c_wen;
    logic [11:0]  c_iaddr;
    logic [2:0]   c_ien;
    logic         c_flush;
    logic [15:0]  c_busy;

    reg_file_mp_sb u_a (
        .clk(clk), .rst_n(rst_n), .raddr(a_raddr), .rdata(a_rdata), .rready(a_rready),
        .waddr(a_waddr), .wdata(a_wdata), .wen(a_wen), .iaddr(a_iaddr), .ien(a_ien),
        .flush(a_flush), .busy(a_busy)
    );

    reg_file_mp_sb #(.NREG(24), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .raddr(b_raddr), .rdata(b_rdata), .rready(b_rready),
        .waddr(b_waddr), .wdata(b_wdata), .wen(b_wen), .iaddr(b_iaddr), .ien(b_ien),
        .flush(b_flush), .busy(b_busy)
    );

    reg_file_mp_sb #(.NREG(16), .NRD(6), .NWR(3), .BYPASS(0), .ZERO_REG(1)) u_c (
        .clk(clk), .rst_n(rst_n), .raddr(c_raddr), .rdata(c_rdata), .rready(c_rready),
        .waddr(c_waddr), .wdata(c_wdata), .wen(c_wen), .iaddr(c_iaddr), .ien(c_ien),
        .flush(c_flush), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [4:0]  ra;
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  ien;
        logic [4:0]  ia0;
        logic [4:0]  ia1;
        logic        fl;
        logic [31:0] erd;
        logic        err;
        logic [31:0] ebusy;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] ra, input logic [1:0] wen,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [1:0] ien, input logic [4:0] ia0,
                                input logic [4:0] ia1, input logic fl,
                                input logic [31:0] erd, input logic err,
                                input logic [31:0] ebusy);
        vec_t v;
        v.ra = ra; v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ien = ien; v.ia0 = ia0; v.ia1 = ia1; v.fl = fl;
        v.erd = erd; v.err = err; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic idle_all();
        a_raddr = '0; a_waddr = '0; a_wdata = '0; a_wen = '0; a_iaddr = '0; a_ien = '0; a_flush = 1'b0;
        b_raddr = '0; b_waddr = '0; b_wdata = '0; b_wen = '0; b_iaddr = '0; b_ien = '0; b_flush = 1'b0;
        c_raddr = '0; c_waddr = '0; c_wdata = '0; c_wen = '0; c_iaddr = '0; c_ien = '0; c_flush = 1'b0;
    endtask

    vec_t        vt [14];
    logic [31:0] mregs [16];
    logic [31:0] nregs [16];
    logic [15:0] mbusy;
    logic [15:0] nbusy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Expected outputs are read before the edge, so ebusy is the state left by earlier rows.
        vt[0]  = mk(7, 2'b11, 7, 32'h11, 7, 32'h22, 2'b00, 0, 0, 0, 32'h22, 1, 32'h0);
        vt[1]  = mk(7, 2'b00, 0, 0, 0, 0, 2'b01, 3, 0, 0, 32'h22, 1, 32'h0);
        vt[2]  = mk(3, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 32'h8);
        vt[3]  = mk(3, 2'b01, 3, 32'h55, 0, 0, 2'b00, 0, 0, 0, 32'h55, 1, 32'h8);
        vt[4]  = mk(3, 2'b01, 4, 32'h44, 0, 0, 2'b01, 4, 0, 0, 32'h55, 1, 32'h0);
        vt[5]  = mk(4, 2'b00, 0, 0, 0, 0, 2'b11, 2, 9, 0, 32'h44, 0, 32'h10);
        vt[6]  = mk(4, 2'b01, 9, 32'h99, 0, 0, 2'b01, 6, 0, 1, 32'h44, 0, 32'h214);
        vt[7]  = mk(9, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h99, 1, 32'h40);
        vt[8]  = mk(0, 2'b01, 0, 32'hFFFF, 0, 0, 2'b01, 0, 0, 0, 32'h0, 1, 32'h40);
        vt[9]  = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 1, 32'h40);
        vt[10] = mk(6, 2'b01, 6, 32'h66, 0, 0, 2'b10, 0, 6, 0, 32'h66, 1, 32'h40);
        vt[11] = mk(6, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h66, 0, 32'h40);
        vt[12] = mk(6, 2'b10, 0, 0, 6, 32'h67, 2'b00, 0, 0, 0, 32'h67, 1, 32'h40);
        vt[13] = mk(6, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h67, 1, 32'h0);

        idle_all();
        rst_n = 1'b0;
        #3;
        chk("reset_busy",   192'(a_busy),   192'(0));
        chk("reset_rready", 192'(a_rready), 192'(4'hF));
        chk("reset_rdata",  192'(a_rdata),  192'(0));
        #9 rst_n = 1'b1;

        // Reset dropped between edges after real state exists
        @(negedge clk);
        a_wen = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'hDEADBEEF};
        a_ien = 2'b10; a_iaddr = {5'd1, 5'd0};
        @(negedge clk);
        idle_all();
        a_raddr = {5'd1, 5'd5, 5'd1, 5'd5};
        #1;
        chk("pre_rst_rdata",  192'(a_rdata),  192'({32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF}));
        chk("pre_rst_rready", 192'(a_rready), 192'(4'b0101));
        chk("pre_rst_busy",   192'(a_busy),   192'(32'h2));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata",  192'(a_rdata),  192'(0));
        chk("mid_rst_rready", 192'(a_rready), 192'(4'hF));
        chk("mid_rst_busy",   192'(a_busy),   192'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            a_raddr = {15'd0, vt[i].ra};
            a_wen   = vt[i].wen;
            a_waddr = {vt[i].wa1, vt[i].wa0};
            a_wdata = {vt[i].wd1, vt[i].wd0};
            a_ien   = vt[i].ien;
            a_iaddr = {vt[i].ia1, vt[i].ia0};
            a_flush = vt[i].fl;
            #1;
            chk($sformatf("vec%0d_rdata", i),  192'(a_rdata[31:0]), 192'(vt[i].erd));
            chk($sformatf("vec%0d_rready", i), 192'(a_rready[0]),   192'(vt[i].err));
            chk($sformatf("vec%0d_busy", i),   192'(a_busy),        192'(vt[i].ebusy));
            @(negedge clk);
        end
        idle_all();

        // B: r0 is ordinary; address 30 is beyond the 24-entry file
        b_wen = 2'b11; b_waddr = {5'd30, 5'd0}; b_wdata = {32'h1234, 32'hFFFF};
        b_ien = 2'b01; b_iaddr = {5'd0, 5'd30};
        b_raddr = {5'd30, 5'd0};
        #1;
        chk("b_byp_r0",      192'(b_rdata[31:0]),  192'(32'hFFFF));
        chk("b_ill_rdata",   192'(b_rdata[63:32]), 192'(0));
        chk("b_ill_rready",  192'(b_rready),       192'(2'b11));
        @(negedge clk);
        b_wen = '0; b_ien = 2'b01; b_iaddr = {5'd0, 5'd0};
        #1;
        chk("b_r0_rdata",    192'(b_rdata),  192'({32'h0, 32'hFFFF}));
        chk("b_r0_rready",   192'(b_rready), 192'(2'b11));
        chk("b_ill_busy",    192'(b_busy),   192'(0));
        @(negedge clk);
        b_ien = '0;
        #1;
        chk("b_r0_busy",     192'(b_busy),      192'(24'h1));
        chk("b_r0_notready", 192'(b_rready[0]), 192'(0));
        @(negedge clk);

        // C: without bypass a writeback is invisible until after the edge
        c_ien = 3'b001; c_iaddr = {4'd0, 4'd0, 4'd5}; c_raddr = 24'd5;
        @(negedge clk);
        c_ien = '0; c_iaddr = '0;
        c_wen = 3'b100; c_waddr = {4'd5, 4'd0, 4'd0}; c_wdata = {32'h5A, 64'h0};
        #1;
        chk("c_wb_old_rdata", 192'(c_rdata[31:0]), 192'(0));
        chk("c_wb_rready",    192'(c_rready[0]),   192'(0));
        chk("c_wb_busy",      192'(c_busy),        192'(16'h20));
        @(negedge clk);
        c_wen = '0;
        #1;
        chk("c_post_rdata",   192'(c_rdata[31:0]), 192'(32'h5A));
        chk("c_post_rready",  192'(c_rready[0]),   192'(1));
        chk("c_post_busy",    192'(c_busy),        192'(0));
        @(negedge clk);

        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mregs[5] = 32'h5A;
        mbusy = '0;

        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int k = 0; k < 6; k++) c_raddr[k*4 +: 4] = 4'($urandom_range(0, 15));
            for (int j = 0; j < 3; j++) begin
                c_wen[j]            = ($urandom_range(0, 1) == 1);
                c_waddr[j*4 +: 4]   = 4'($urandom_range(0, 15));
                c_wdata[j*32 +: 32] = $urandom;
                c_ien[j]            = ($urandom_range(0, 2) == 0);
                c_iaddr[j*4 +: 4]   = 4'($urandom_range(0, 15));
            end
            c_flush = ($urandom_range(0, 15) == 0);
            #1;
            for (int k = 0; k < 6; k++) begin
                logic [3:0] a;
                a = c_raddr[k*4 +: 4];
                chk($sformatf("rnd%0d_rd%0d", cyc, k), 192'(c_rdata[k*32 +: 32]),
                    192'((a == 4'd0) ? 32'h0 : mregs[a]));
                chk($sformatf("rnd%0d_rr%0d", cyc, k), 192'(c_rready[k]),
                    192'((a == 4'd0) ? 1'b1 : !mbusy[a]));
            end
            chk($sformatf("rnd%0d_busy", cyc), 192'(c_busy), 192'(mbusy));
            for (int i = 0; i < 16; i++) begin
                logic s;
                logic c;
                s = 1'b0;
                c = 1'b0;
                nregs[i] = mregs[i];
                for (int j = 0; j < 3; j++) begin
                    if (i != 0 && c_wen[j] && c_waddr[j*4 +: 4] == 4'(i)) begin
                        c = 1'b1;
                        nregs[i] = c_wdata[j*32 +: 32];
                    end
                    if (i != 0 && c_ien[j] && c_iaddr[j*4 +: 4] == 4'(i)) s = 1'b1;
                end
                nbusy[i] = s ? 1'b1 : ((c_flush || c) ? 1'b0 : mbusy[i]);
            end
            @(negedge clk);
            for (int i = 0; i < 16; i++) mregs[i] = nregs[i];
            mbusy = nbusy;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
